// File: rtl/free_list_bitmap_pkg.sv
// Shared rename-stage constants and types for the physical-register free list.
// Also provides the 64-bit popcount used for the free counter and its invariant.
package free_list_bitmap_pkg;

  localparam int NUM_PREGS    = 64;
  localparam int PREG_IDX_W   = 6;
  localparam int NUM_ARCH     = 32;
  localparam int RENAME_WIDTH = 3;
  localparam int COUNT_W      = PREG_IDX_W + 1;

  typedef logic [PREG_IDX_W-1:0] preg_idx_t;
  typedef logic [COUNT_W-1:0]    preg_count_t;

  // Pregs 0..NUM_ARCH-1 hold the architectural mapping out of reset.
  localparam logic [NUM_PREGS-1:0] FREE_RESET_MASK =
    {{(NUM_PREGS - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

  function automatic preg_count_t popcount64(input logic [NUM_PREGS-1:0] v);
    preg_count_t n;
    n = '0;
    for (int b = 0; b < NUM_PREGS; b++) n = n + preg_count_t'(v[b]);
    return n;
  endfunction

endpackage

// File: rtl/free_list_bitmap_penc3.sv
// Triple priority encoder: lane i reports the (i+1)-th lowest set bit of data_i.
// The index is reported whenever a candidate exists; valid_o also needs the lane enable.
module free_list_bitmap_penc3
  import free_list_bitmap_pkg::*;
(
  input  logic [NUM_PREGS-1:0]    data_i,
  input  logic [RENAME_WIDTH-1:0] en_i,
  output logic [RENAME_WIDTH-1:0] valid_o,
  output logic [PREG_IDX_W-1:0]   idx0_o,
  output logic [PREG_IDX_W-1:0]   idx1_o,
  output logic [PREG_IDX_W-1:0]   idx2_o
);

  function automatic logic [PREG_IDX_W:0] lowest_set(input logic [NUM_PREGS-1:0] v);
    logic [PREG_IDX_W:0] r;
    r = '0;
    for (int b = NUM_PREGS - 1; b >= 0; b--) begin
      if (v[b]) r = {1'b1, PREG_IDX_W'(b)};
    end
    return r;
  endfunction

  logic [NUM_PREGS-1:0]  remaining;
  logic [PREG_IDX_W:0]   hit [RENAME_WIDTH];

  always_comb begin
    remaining = data_i;
    for (int l = 0; l < RENAME_WIDTH; l++) begin
      hit[l] = lowest_set(remaining);
      if (hit[l][PREG_IDX_W]) remaining[hit[l][PREG_IDX_W-1:0]] = 1'b0;
      valid_o[l] = en_i[l] & hit[l][PREG_IDX_W];
    end
  end

  assign idx0_o = hit[0][PREG_IDX_W-1:0];
  assign idx1_o = hit[1][PREG_IDX_W-1:0];
  assign idx2_o = hit[2][PREG_IDX_W-1:0];

endmodule

// File: rtl/free_list_bitmap.sv
// Physical-register free list for a 3-wide rename stage: speculative and committed
// bitmaps, all-or-nothing 3-lane allocation, commit-time release and one-cycle flush.
module free_list_bitmap
  import free_list_bitmap_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            alloc_req,
  output logic                  alloc_ok,
  output logic [2:0]            alloc_valid,
  output logic [PREG_IDX_W-1:0] alloc_idx0,
  output logic [PREG_IDX_W-1:0] alloc_idx1,
  output logic [PREG_IDX_W-1:0] alloc_idx2,
  input  logic [2:0]            commit_valid,
  input  logic [PREG_IDX_W-1:0] commit_new_preg0,
  input  logic [PREG_IDX_W-1:0] commit_new_preg1,
  input  logic [PREG_IDX_W-1:0] commit_new_preg2,
  input  logic [PREG_IDX_W-1:0] commit_old_preg0,
  input  logic [PREG_IDX_W-1:0] commit_old_preg1,
  input  logic [PREG_IDX_W-1:0] commit_old_preg2,
  input  logic                  flush,
  output logic [COUNT_W-1:0]    free_count
);

  logic [NUM_PREGS-1:0] spec_free_q, spec_free_d;
  logic [NUM_PREGS-1:0] comm_free_q, comm_free_d;
  preg_count_t          free_count_q, free_count_d;

  logic [RENAME_WIDTH-1:0] req_therm, cand_valid;
  preg_idx_t               cand_idx [RENAME_WIDTH];
  preg_idx_t               new_preg [RENAME_WIDTH];
  preg_idx_t               old_preg [RENAME_WIDTH];
  preg_count_t             req_n, granted_n, released_n;
  logic [NUM_PREGS-1:0]    grant_mask, new_mask, rel_mask;

  assign new_preg[0] = commit_new_preg0;
  assign new_preg[1] = commit_new_preg1;
  assign new_preg[2] = commit_new_preg2;
  assign old_preg[0] = commit_old_preg0;
  assign old_preg[1] = commit_old_preg1;
  assign old_preg[2] = commit_old_preg2;

  // Lanes above the first unrequested lane are ignored.
  assign req_therm = {&alloc_req, &alloc_req[1:0], alloc_req[0]};
  assign req_n     = preg_count_t'(req_therm[0]) + preg_count_t'(req_therm[1])
                   + preg_count_t'(req_therm[2]);

  free_list_bitmap_penc3 u_penc3 (
    .data_i  (spec_free_q),
    .en_i    (req_therm),
    .valid_o (cand_valid),
    .idx0_o  (cand_idx[0]),
    .idx1_o  (cand_idx[1]),
    .idx2_o  (cand_idx[2])
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alloc_ok    = 1'b0;
    alloc_valid = '0;
    alloc_idx0  = '0;
    alloc_idx1  = '0;
    alloc_idx2  = '0;
    if (!reset) begin
      alloc_ok    = (free_count_q >= req_n) && !flush;
      alloc_valid = alloc_ok ? (req_therm & cand_valid) : '0;
      alloc_idx0  = cand_idx[0];
      alloc_idx1  = cand_idx[1];
      alloc_idx2  = cand_idx[2];
    end
  end

  always_comb begin
    grant_mask = '0;
    new_mask   = '0;
    rel_mask   = '0;
    for (int l = 0; l < RENAME_WIDTH; l++) begin
      if (alloc_valid[l])  grant_mask[cand_idx[l]] = 1'b1;
      if (commit_valid[l]) new_mask[new_preg[l]]   = 1'b1;
      // Preg 0 is never returned to the free list.
      if (commit_valid[l] && old_preg[l] != '0) rel_mask[old_preg[l]] = 1'b1;
    end
    granted_n   = preg_count_t'(alloc_valid[0]) + preg_count_t'(alloc_valid[1])
                + preg_count_t'(alloc_valid[2]);
    // Only 0->1 transitions count, so duplicate or already-free releases add nothing.
    released_n  = popcount64(rel_mask & ~spec_free_q);
    comm_free_d = (comm_free_q & ~new_mask) | rel_mask;
    if (flush) begin
      spec_free_d  = comm_free_d;
      free_count_d = popcount64(comm_free_d);
    end else begin
      spec_free_d  = (spec_free_q & ~grant_mask) | rel_mask;
      free_count_d = free_count_q + released_n - granted_n;
    end
  end

  // NOTE: both bitmaps are plain flop vectors with a known reset image, not a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      spec_free_q  <= FREE_RESET_MASK;
      comm_free_q  <= FREE_RESET_MASK;
      free_count_q <= preg_count_t'(NUM_PREGS - NUM_ARCH);
    end else begin
      spec_free_q  <= spec_free_d;
      comm_free_q  <= comm_free_d;
      free_count_q <= free_count_d;
    end
  end

  assign free_count = free_count_q;

  a_count_matches: assert property (@(posedge clk) disable iff (reset)
    free_count_q == popcount64(spec_free_q));

  a_req_thermometer: assert property (@(posedge clk) disable iff (reset)
    alloc_req inside {3'b000, 3'b001, 3'b011, 3'b111});

  a_no_dup_release: assert property (@(posedge clk) disable iff (reset)
    !((&commit_valid[1:0] && old_preg[0] == old_preg[1] && old_preg[0] != '0) ||
      (commit_valid[0] && commit_valid[2] && old_preg[0] == old_preg[2] && old_preg[0] != '0) ||
      (&commit_valid[2:1] && old_preg[1] == old_preg[2] && old_preg[1] != '0)));

  for (genvar l = 0; l < RENAME_WIDTH; l++) begin : g_lane_chk
    a_release_in_use: assert property (@(posedge clk) disable iff (reset)
      (commit_valid[l] && old_preg[l] != '0) |-> !spec_free_q[old_preg[l]]);
    a_new_ne_old: assert property (@(posedge clk) disable iff (reset)
      commit_valid[l] |-> new_preg[l] != old_preg[l]);
  end

endmodule

// File: tb/tb_free_list_bitmap.sv
// Self-checking bench for free_list_bitmap: directed scenarios plus randomized legal
// rename/commit/flush traffic against a free-list model kept as plain bit arrays.
module tb_free_list_bitmap;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alloc_req;
  logic       alloc_ok;
  logic [2:0] alloc_valid;
  logic [5:0] alloc_idx0, alloc_idx1, alloc_idx2;
  logic [2:0] commit_valid;
  logic [5:0] c_new [3];
  logic [5:0] c_old [3];
  logic       flush;
  logic [6:0] free_count;

  always #5 clk = ~clk;

  free_list_bitmap dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_req        (alloc_req),
    .alloc_ok         (alloc_ok),
    .alloc_valid      (alloc_valid),
    .alloc_idx0       (alloc_idx0),
    .alloc_idx1       (alloc_idx1),
    .alloc_idx2       (alloc_idx2),
    .commit_valid     (commit_valid),
    .commit_new_preg0 (c_new[0]),
    .commit_new_preg1 (c_new[1]),
    .commit_new_preg2 (c_new[2]),
    .commit_old_preg0 (c_old[0]),
    .commit_old_preg1 (c_old[1]),
    .commit_old_preg2 (c_old[2]),
    .flush            (flush),
    .free_count       (free_count)
  );

  // Reference model: one flag per physical register, 1 = free.
  bit         m_spec [64];
  bit         m_comm [64];
  logic       e_ok;
  logic [2:0] e_valid;
  logic [5:0] e_idx [3];
  logic [21:0] exp_bundle;
  int         n_vec  = 0;
  int         n_miss = 0;

  function automatic int free_total();
    int n = 0;
    for (int p = 0; p < 64; p++) if (m_spec[p]) n++;
    return n;
  endfunction

  function automatic logic [5:0] nth_free(input int n);
    int seen = 0;
    for (int p = 0; p < 64; p++) begin
      if (m_spec[p]) begin
        if (seen == n) return 6'(p);
        seen++;
      end
    end
    return 6'd0;
  endfunction

  function automatic logic [21:0] got_bundle();
    return {alloc_ok, alloc_valid, alloc_idx0, alloc_idx1, alloc_idx2};
  endfunction

  task automatic set_commit(input logic [2:0] cv, input int n0, input int n1, input int n2,
                            input int o0, input int o1, input int o2);
    commit_valid = cv;
    c_new[0] = 6'(n0); c_new[1] = 6'(n1); c_new[2] = 6'(n2);
    c_old[0] = 6'(o0); c_old[1] = 6'(o1); c_old[2] = 6'(o2);
  endtask

  // Drive one cycle's inputs, then move to the falling edge and form expectations.
  task automatic apply(input logic rst, input logic [2:0] req, input logic fl);
    int want;
    reset = rst; alloc_req = req; flush = fl;
    @(negedge clk);
    want = 0;
    if (req[0]) want = 1;
    if (req[0] && req[1]) want = 2;
    if (req == 3'b111) want = 3;
    e_ok = 1'b0; e_valid = 3'b000;
    for (int i = 0; i < 3; i++) e_idx[i] = 6'd0;
    if (!rst) begin
      e_ok    = (free_total() >= want) && !fl;
      e_valid = e_ok ? 3'((1 << want) - 1) : 3'b000;
      for (int i = 0; i < 3; i++) e_idx[i] = nth_free(i);
    end
    exp_bundle = {e_ok, e_valid, e_idx[0], e_idx[1], e_idx[2]};
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int p = 0; p < 64; p++) begin
        m_spec[p] = (p >= 32);
        m_comm[p] = (p >= 32);
      end
    end else begin
      for (int l = 0; l < 3; l++) if (commit_valid[l]) m_comm[c_new[l]] = 1'b0;
      for (int l = 0; l < 3; l++) if (commit_valid[l] && c_old[l] != 0) m_comm[c_old[l]] = 1'b1;
      if (flush) begin
        m_spec = m_comm;
      end else begin
        for (int l = 0; l < 3; l++) if (e_valid[l]) m_spec[e_idx[l]] = 1'b0;
        for (int l = 0; l < 3; l++) if (commit_valid[l] && c_old[l] != 0) m_spec[c_old[l]] = 1'b1;
      end
    end
    #1;
    set_commit(3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    set_commit(3'b000, 0, 0, 0, 0, 0, 0);
    apply(1'b1, 3'b000, 1'b0); tick();
    apply(1'b1, 3'b000, 1'b0); tick();
  endtask

  task automatic test_reset();
    set_commit(3'b000, 0, 0, 0, 0, 0, 0);
    apply(1'b1, 3'b111, 1'b0); tick();
    apply(1'b1, 3'b111, 1'b0);
    n_vec++;
    if (got_bundle() !== 22'd0) begin
      n_miss++; $display("FAIL reset_outputs: got %h want 0", got_bundle());
    end
    tick();
    apply(1'b0, 3'b000, 1'b0);
    n_vec++;
    if (free_count !== 7'd32) begin
      n_miss++; $display("FAIL reset_count: got %0d want 32", free_count);
    end
    n_vec++;
    if (got_bundle() !== exp_bundle) begin
      n_miss++; $display("FAIL reset_idle: got %h want %h", got_bundle(), exp_bundle);
    end
    tick();
  endtask

  task automatic test_basic_alloc();
    apply(1'b0, 3'b111, 1'b0);
    n_vec++;
    if ({alloc_ok, alloc_idx0, alloc_idx1, alloc_idx2} !== {1'b1, 6'd32, 6'd33, 6'd34}) begin
      n_miss++; $display("FAIL first_triple: got ok=%b %0d/%0d/%0d want 1 32/33/34",
                         alloc_ok, alloc_idx0, alloc_idx1, alloc_idx2);
    end
    tick();
    apply(1'b0, 3'b111, 1'b0);
    n_vec++;
    if (free_count !== 7'd29) begin
      n_miss++; $display("FAIL count_after_triple: got %0d want 29", free_count);
    end
    n_vec++;
    if ({alloc_valid, alloc_idx0, alloc_idx1, alloc_idx2} !== {3'b111, 6'd35, 6'd36, 6'd37}) begin
      n_miss++; $display("FAIL second_triple: got %b %0d/%0d/%0d want 111 35/36/37",
                         alloc_valid, alloc_idx0, alloc_idx1, alloc_idx2);
    end
    tick();
  endtask

  task automatic test_empty();
    for (int guard = 0; guard < 30 && free_total() >= 3; guard++) begin
      apply(1'b0, 3'b111, 1'b0);
      n_vec++;
      if (got_bundle() !== exp_bundle) begin
        n_miss++; $display("FAIL drain: got %h want %h", got_bundle(), exp_bundle);
      end
      tick();
    end
    apply(1'b0, 3'b111, 1'b0);
    n_vec++;
    if ({free_count, alloc_ok, alloc_valid} !== {7'd2, 1'b0, 3'b000}) begin
      n_miss++; $display("FAIL short_list: got cnt=%0d ok=%b v=%b want 2 0 000",
                         free_count, alloc_ok, alloc_valid);
    end
    tick();
    apply(1'b0, 3'b011, 1'b0);
    n_vec++;
    if ({free_count, alloc_valid, alloc_idx0, alloc_idx1} !== {7'd2, 3'b011, 6'd62, 6'd63}) begin
      n_miss++; $display("FAIL last_two: got cnt=%0d v=%b %0d/%0d want 2 011 62/63",
                         free_count, alloc_valid, alloc_idx0, alloc_idx1);
    end
    tick();
    apply(1'b0, 3'b001, 1'b0);
    n_vec++;
    if ({free_count, alloc_ok, alloc_valid} !== {7'd0, 1'b0, 3'b000}) begin
      n_miss++; $display("FAIL empty_list: got cnt=%0d ok=%b v=%b want 0 0 000",
                         free_count, alloc_ok, alloc_valid);
    end
    tick();
  endtask

  task automatic test_commit_alloc();
    do_reset();
    apply(1'b0, 3'b001, 1'b0); tick();
    set_commit(3'b001, 32, 0, 0, 5, 0, 0);
    apply(1'b0, 3'b001, 1'b0);
    n_vec++;
    if ({alloc_valid, alloc_idx0} !== {3'b001, 6'd33}) begin
      n_miss++; $display("FAIL release_hidden: got v=%b idx0=%0d want 001 33", alloc_valid, alloc_idx0);
    end
    tick();
    apply(1'b0, 3'b001, 1'b0);
    n_vec++;
    if ({free_count, alloc_idx0} !== {7'd31, 6'd5}) begin
      n_miss++; $display("FAIL release_visible: got cnt=%0d idx0=%0d want 31 5", free_count, alloc_idx0);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin apply(1'b0, 3'b111, 1'b0); tick(); end
    set_commit(3'b111, 32, 33, 34, 1, 2, 3);
    apply(1'b0, 3'b000, 1'b0); tick();
    apply(1'b0, 3'b111, 1'b1);
    n_vec++;
    if ({alloc_ok, alloc_valid} !== 4'b0000) begin
      n_miss++; $display("FAIL flush_blocks: got ok=%b v=%b want 0 000", alloc_ok, alloc_valid);
    end
    tick();
    apply(1'b0, 3'b111, 1'b0);
    n_vec++;
    if ({free_count, alloc_idx0, alloc_idx1, alloc_idx2} !== {7'd32, 6'd1, 6'd2, 6'd3}) begin
      n_miss++; $display("FAIL flush_restore: got cnt=%0d %0d/%0d/%0d want 32 1/2/3",
                         free_count, alloc_idx0, alloc_idx1, alloc_idx2);
    end
    tick();
    apply(1'b0, 3'b111, 1'b0);
    n_vec++;
    if ({alloc_idx0, alloc_idx1, alloc_idx2} !== {6'd35, 6'd36, 6'd37}) begin
      n_miss++; $display("FAIL flush_skips_committed: got %0d/%0d/%0d want 35/36/37",
                         alloc_idx0, alloc_idx1, alloc_idx2);
    end
    tick();
  endtask

  task automatic test_release_zero();
    do_reset();
    apply(1'b0, 3'b001, 1'b0); tick();
    set_commit(3'b001, 32, 0, 0, 0, 0, 0);
    apply(1'b0, 3'b000, 1'b0); tick();
    apply(1'b0, 3'b001, 1'b0);
    n_vec++;
    if ({free_count, alloc_idx0} !== {7'd31, 6'd33}) begin
      n_miss++; $display("FAIL preg0_kept: got cnt=%0d idx0=%0d want 31 33", free_count, alloc_idx0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_commit(3'b000, 0, 0, 0, 0, 0, 0);
    apply(1'b0, 3'b111, 1'b0); tick();
    set_commit(3'b111, 33, 34, 35, 6, 7, 8);
    apply(1'b1, 3'b111, 1'b1);
    n_vec++;
    if (got_bundle() !== 22'd0) begin
      n_miss++; $display("FAIL reset_mid_outputs: got %h want 0", got_bundle());
    end
    tick();
    apply(1'b0, 3'b111, 1'b0);
    n_vec++;
    if ({free_count, alloc_idx0, alloc_idx1, alloc_idx2} !== {7'd32, 6'd32, 6'd33, 6'd34}) begin
      n_miss++; $display("FAIL reset_mid_state: got cnt=%0d %0d/%0d/%0d want 32 32/33/34",
                         free_count, alloc_idx0, alloc_idx1, alloc_idx2);
    end
    tick();
  endtask

  task automatic test_random();
    logic [2:0] reqs [4];
    int inflight [$];
    int committed [$];
    int i, j;
    reqs[0] = 3'b000; reqs[1] = 3'b001; reqs[2] = 3'b011; reqs[3] = 3'b111;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      inflight.delete();
      committed.delete();
      for (int p = 0; p < 64; p++) begin
        if (!m_spec[p] && m_comm[p]) inflight.push_back(p);
        if (!m_comm[p]) committed.push_back(p);
      end
      set_commit(3'b000, 0, 0, 0, 0, 0, 0);
      for (int l = 0; l < 3; l++) begin
        if ($urandom_range(0, 1) == 1 && inflight.size() > 0 && committed.size() > 0) begin
          i = $urandom_range(0, inflight.size() - 1);
          j = $urandom_range(0, committed.size() - 1);
          c_new[l] = 6'(inflight[i]);
          c_old[l] = 6'(committed[j]);
          inflight.delete(i);
          committed.delete(j);
          commit_valid[l] = 1'b1;
        end
      end
      apply(1'b0, reqs[$urandom_range(0, 3)], $urandom_range(0, 15) == 0);
      n_vec++;
      if (got_bundle() !== exp_bundle) begin
        n_miss++; $display("FAIL rand_grant cyc %0d: got %h want %h", cyc, got_bundle(), exp_bundle);
      end
      n_vec++;
      if (free_count !== 7'(free_total())) begin
        n_miss++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, free_count, free_total());
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; alloc_req = 3'b000; flush = 1'b0;
    set_commit(3'b000, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic_alloc();
    test_empty();
    test_commit_alloc();
    test_flush();
    test_release_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
